dl_shift_seq: RTL and testbench

- Multi-cycle shift sequencer. Accepts one shift operation at a time over a valid/ready handshake.
- Performs the shift with a narrow per-cycle shifter of at most MAX_STEP positions per cycle, iterating until the full shift amount is applied.
- Returns the result over a second valid/ready handshake.
- Used in area-constrained execute stages as a replacement for a full-width barrel shifter.

---
 rtl/dl_shift_seq.sv | 127 ++++++++++++
 tb/tb_dl_shift_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_shift_seq.sv
// Multi-cycle shift sequencer: applies SLL/SRL/SRA/ROR through a narrow
// shifter of at most MAX_STEP positions per cycle, with valid/ready on both sides.
module dl_shift_seq #(
    parameter int NUM_BITS = 32,
    parameter int MAX_STEP = 8,
    localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_BITS-1:0]       in_a,
    input  logic [NUM_SHIFT_BITS-1:0] in_shamt,
    input  logic [1:0]                in_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_BITS-1:0]       out_data,
    output logic                      busy
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // ready/valid come from the state register only, never from the partner's signal.

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    // One extra bit so MAX_STEP == NUM_BITS is representable for the compare.
    localparam logic [NUM_SHIFT_BITS:0] MAX_STEP_W = (NUM_SHIFT_BITS + 1)'(MAX_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic [NUM_BITS-1:0]       work;
    logic [1:0]                op_q;
    logic [NUM_SHIFT_BITS-1:0] remaining;
    logic [NUM_SHIFT_BITS-1:0] step;
    logic [NUM_SHIFT_BITS-1:0] rem_next;
    logic [NUM_BITS-1:0]       shifted;
    logic [2*NUM_BITS-1:0]     rot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = (in_shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (rem_next == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Narrow step shifter; each step is a complete shift so iterating is exact.
    always_comb begin
        step     = remaining;
        rem_next = '0;
        shifted  = work;
        rot      = '0;
        if ({1'b0, remaining} >= MAX_STEP_W) begin
            step = MAX_STEP_W[NUM_SHIFT_BITS-1:0];
        end
        rem_next = remaining - step;
        case (op_q)
            OP_SLL: shifted = work << step;
            OP_SRL: shifted = work >> step;
            OP_SRA: shifted = NUM_BITS'($signed(work) >>> step);
            OP_ROR: begin
                rot     = {work, work} >> step;
                shifted = rot[NUM_BITS-1:0];
            end
            default: shifted = work;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work      <= '0;
            op_q      <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work      <= in_a;
                        op_q      <= in_op;
                        remaining <= in_shamt;
                    end
                end
                SHIFT: begin
                    work      <= shifted;
                    remaining <= rem_next;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = work;

endmodule

// File: tb/tb_dl_shift_seq.sv
// Self-checking bench for dl_shift_seq: scoreboard queue of expected results,
// one task per scenario, summary line at the end.
module tb_dl_shift_seq;
    localparam int W = 32;
    localparam int SW = 5;
    localparam int STEP = 8;
    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] ROR = 2'b10;
    localparam logic [1:0] SRA = 2'b11;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [SW-1:0] in_shamt;
    logic [1:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];

    dl_shift_seq #(.NUM_BITS(W), .MAX_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int s,
                                               input logic [1:0] op);
        logic [W-1:0] r;
        case (op)
            SLL: r = a << s;
            SRL: r = a >> s;
            SRA: r = $signed(a) >>> s;
            default: r = (s == 0) ? a : ((a >> s) | (a << (W - s)));
        endcase
        return r;
    endfunction

    // driver: present a request and wait for it to be accepted
    task automatic send(input logic [W-1:0] a, input logic [SW-1:0] s, input logic [1:0] op,
                        output int acc_cyc, output bit ok);
        ok = 1'b0;
        acc_cyc = 0;
        in_a = a;
        in_shamt = s;
        in_op = op;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_a = $urandom;
        in_shamt = SW'($urandom_range(0, W - 1));
        in_op = 2'($urandom_range(0, 3));
        if (ok) exp_q.push_back(ref_shift(a, int'(s), op));
    endtask

    // monitor: wait for out_valid, returns sampled at that negedge
    task automatic wait_out(output logic [W-1:0] data, output int out_cyc, output bit ok);
        ok = 1'b0;
        data = '0;
        out_cyc = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                data = out_data;
                out_cyc = cyc;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_srl_steps();
        int acc, oc;
        bit ok_a, ok_o;
        logic [W-1:0] d, e;
        out_ready = 1'b1;
        send(32'h8000_0000, 5'd31, SRL, acc, ok_a);
        checks++; if (!ok_a) begin errors++; $display("FAIL srl_accept timeout"); end
        wait_out(d, oc, ok_o);
        checks++; if (!ok_o) begin errors++; $display("FAIL srl_out timeout"); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (d !== e || d !== 32'h1) begin errors++; $display("FAIL srl_data got %h want %h", d, e); end
        checks++; if (oc - acc !== 5) begin errors++; $display("FAIL srl_latency got %0d want 5", oc - acc); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL srl_drop got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h1) begin errors++; $display("FAIL srl_hold got %h want 00000001", out_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_ops_table();
        logic [W-1:0]  ta[8] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'hF,
                                 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        logic [SW-1:0] ts[8] = '{5'd4, 5'd17, 5'd1, 5'd28, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [1:0]    to[8] = '{SRA, SRA, ROR, SLL, SLL, SRL, ROR, SRA};
        logic [W-1:0]  tk[8] = '{32'hF800_0000, 32'h0000_3FFF, 32'h8000_0000, 32'hF000_0000,
                                 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        int acc, oc, lat;
        bit ok_a, ok_o;
        logic [W-1:0] d, e;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(ta[k], ts[k], to[k], acc, ok_a);
            wait_out(d, oc, ok_o);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            lat = 1 + (int'(ts[k]) + STEP - 1) / STEP;
            checks++; if (!ok_a || !ok_o) begin errors++; $display("FAIL op%0d_handshake timeout acc=%b out=%b", k, ok_a, ok_o); end
            checks++; if (d !== e || d !== tk[k]) begin errors++; $display("FAIL op%0d_data got %h want %h", k, d, tk[k]); end
            checks++; if (oc - acc !== lat) begin errors++; $display("FAIL op%0d_latency got %0d want %0d", k, oc - acc, lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int acc, oc;
        bit ok_a, ok_o;
        logic [W-1:0] d, e;
        out_ready = 1'b0;
        send(32'h1, 5'd9, SLL, acc, ok_a);
        wait_out(d, oc, ok_o);
        checks++; if (!ok_a || !ok_o) begin errors++; $display("FAIL bp_handshake timeout acc=%b out=%b", ok_a, ok_o); end
        checks++; if (oc - acc !== 3) begin errors++; $display("FAIL bp_latency got %0d want 3", oc - acc); end
        e = (exp_q.size() > 0) ? exp_q[0] : 'x;
        in_a = 32'h5;
        in_shamt = 5'd0;
        in_op = SLL;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (out_data !== e || out_data !== 32'h200) begin errors++; $display("FAIL bp_hold_data got %h want %h", out_data, e); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b want 1", out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready got %b want 0", in_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_hold_busy got %b want 1", busy); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_early_accept busy=%b in_ready=%b want 0/1", busy, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(32'h5);
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (out_valid !== 1'b1 || out_data !== e) begin errors++; $display("FAIL bp_second got valid=%b data=%h want 1/%h", out_valid, out_data, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int acc, oc;
        bit ok_a, ok_o;
        logic [W-1:0] d, e;
        out_ready = 1'b1;
        send(32'hFFFF_0000, 5'd31, SRL, acc, ok_a);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rmid_out_data got %h want 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        send(32'h100, 5'd8, SRL, acc, ok_a);
        wait_out(d, oc, ok_o);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (!ok_a || !ok_o) begin errors++; $display("FAIL rmid_handshake timeout acc=%b out=%b", ok_a, ok_o); end
        checks++; if (d !== e || d !== 32'h1) begin errors++; $display("FAIL rmid_data got %h want %h", d, e); end
        checks++; if (oc - acc !== 2) begin errors++; $display("FAIL rmid_latency got %0d want 2", oc - acc); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int acc, oc, lat, hold;
        bit ok_a, ok_o;
        logic [W-1:0] d, e, a;
        logic [SW-1:0] s;
        logic [1:0] op;
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            a = $urandom;
            s = SW'($urandom_range(0, W - 1));
            op = 2'($urandom_range(0, 3));
            out_ready = 1'($urandom_range(0, 1));
            send(a, s, op, acc, ok_a);
            wait_out(d, oc, ok_o);
            lat = 1 + (int'(s) + STEP - 1) / STEP;
            checks++; if (!ok_a || !ok_o) begin errors++; $display("FAIL b2b%0d_handshake timeout acc=%b out=%b", k, ok_a, ok_o); end
            checks++; if (oc - acc !== lat) begin errors++; $display("FAIL b2b%0d_latency got %0d want %0d", k, oc - acc, lat); end
            if (!out_ready) begin
                hold = $urandom_range(0, 3);
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++; if (out_data !== e) begin errors++; $display("FAIL b2b%0d_data got %h want %h", k, out_data, e); end
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b%0d_duplicate out_valid got %b want 0", k, out_valid); end
            @(posedge clk); #1;
        end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_queue_empty got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        in_valid = 1'b0;
        in_a = '0;
        in_shamt = '0;
        in_op = SLL;
        out_ready = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_srl_steps();
        test_ops_table();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
